// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin sharing of one AXI write port; the grant is held from AW through the B response.
module axi_wr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 64,
   parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                              clk,
   input  logic                              areset,
   input  logic [NUM_MASTERS*4-1:0]          s_awid_i,
   input  logic [NUM_MASTERS*4-1:0]          s_awlen_i,
   input  logic [NUM_MASTERS*3-1:0]          s_awsize_i,
   input  logic [NUM_MASTERS*2-1:0]          s_awburst_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr_i,
   input  logic [NUM_MASTERS-1:0]            s_awvalid_i,
   output logic [NUM_MASTERS-1:0]            s_awready_o,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata_i,
   input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_wstrb_i,
   input  logic [NUM_MASTERS-1:0]            s_wlast_i,
   input  logic [NUM_MASTERS-1:0]            s_wvalid_i,
   output logic [NUM_MASTERS-1:0]            s_wready_o,
   output logic [NUM_MASTERS*4-1:0]          s_bid_o,
   output logic [NUM_MASTERS*2-1:0]          s_bresp_o,
   output logic [NUM_MASTERS-1:0]            s_bvalid_o,
   input  logic [NUM_MASTERS-1:0]            s_bready_i,
   output logic [3:0]                        m_awid_o,
   output logic [3:0]                        m_awlen_o,
   output logic [2:0]                        m_awsize_o,
   output logic [1:0]                        m_awburst_o,
   output logic [ADDR_WIDTH-1:0]             m_awaddr_o,
   output logic                              m_awvalid_o,
   input  logic                              m_awready_i,
   output logic [DATA_WIDTH-1:0]             m_wdata_o,
   output logic [STRB_WIDTH-1:0]             m_wstrb_o,
   output logic                              m_wlast_o,
   output logic                              m_wvalid_o,
   input  logic                              m_wready_i,
   input  logic [3:0]                        m_bid_i,
   input  logic [1:0]                        m_bresp_i,
   input  logic                              m_bvalid_i,
   output logic                              m_bready_o,
   output logic [NUM_MASTERS-1:0]            grant_o,
   output logic                              busy_o,
   output logic [1:0]                        state_o
);
   localparam int IW = $clog2(NUM_MASTERS);
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;
   state_t                 r_state, w_state_nxt;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [IW-1:0]          r_idx, r_ptr, w_pick;
   logic                   w_addr, w_data, w_resp, w_req, w_aw_hs, w_w_hs, w_b_hs;

   // first requester at or after ptr, wrapping modulo NUM_MASTERS
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req, input logic [IW-1:0] ptr);
      logic [IW-1:0] j;
      rr_pick = ptr;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % NUM_MASTERS);
         if (req[j]) rr_pick = j;
      end
   endfunction

   assign w_addr  = r_state == ADDR;
   assign w_data  = r_state == DATA;
   assign w_resp  = r_state == RESP;
   assign w_req   = (r_state == IDLE) && (|s_awvalid_i);
   assign w_pick  = rr_pick(s_awvalid_i, r_ptr);
   assign w_aw_hs = m_awvalid_o & m_awready_i;
   assign w_w_hs  = m_wvalid_o & m_wready_i & m_wlast_o;
   assign w_b_hs  = m_bvalid_i & m_bready_o;

   assign m_awvalid_o = w_addr & s_awvalid_i[r_idx];
   assign m_awid_o    = w_addr ? s_awid_i[int'(r_idx)*4 +: 4] : '0;
   assign m_awlen_o   = w_addr ? s_awlen_i[int'(r_idx)*4 +: 4] : '0;
   assign m_awsize_o  = w_addr ? s_awsize_i[int'(r_idx)*3 +: 3] : '0;
   assign m_awburst_o = w_addr ? s_awburst_i[int'(r_idx)*2 +: 2] : '0;
   assign m_awaddr_o  = w_addr ? s_awaddr_i[int'(r_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign m_wvalid_o  = w_data & s_wvalid_i[r_idx];
   assign m_wdata_o   = w_data ? s_wdata_i[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign m_wstrb_o   = w_data ? s_wstrb_i[int'(r_idx)*STRB_WIDTH +: STRB_WIDTH] : '0;
   assign m_wlast_o   = w_data & s_wlast_i[r_idx];
   assign m_bready_o  = w_resp & s_bready_i[r_idx];

   assign s_awready_o = r_grant & {NUM_MASTERS{w_addr & m_awready_i}};
   assign s_wready_o  = r_grant & {NUM_MASTERS{w_data & m_wready_i}};
   assign s_bvalid_o  = r_grant & {NUM_MASTERS{w_resp & m_bvalid_i}};

   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_b
      assign s_bid_o[k*4 +: 4]   = (w_resp & r_grant[k]) ? m_bid_i : '0;
      assign s_bresp_o[k*2 +: 2] = (w_resp & r_grant[k]) ? m_bresp_i : '0;
   end

   assign grant_o = r_grant;
   assign busy_o  = r_state != IDLE;
   assign state_o = r_state;

   always_comb begin
      w_state_nxt = r_state;
      if (w_req) w_state_nxt = ADDR;
      if (w_aw_hs) w_state_nxt = DATA;
      if (w_w_hs) w_state_nxt = RESP;
      if (w_b_hs) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge areset)
      if (!areset) r_state <= IDLE;
      else r_state <= w_state_nxt;

   always_ff @(posedge clk or negedge areset)
      if (!areset) begin
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
      end else if (w_req) begin
         r_grant <= NUM_MASTERS'(1) << w_pick;
         r_idx   <= w_pick;
      end else if (w_b_hs) begin
         r_grant <= '0;
         r_ptr   <= (r_idx == IW'(NUM_MASTERS - 1)) ? '0 : r_idx + 1'b1;
      end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Shares one AXI write port (AW/W/B) between NUM_MASTERS counter masters. Each master is a counter write engine.
- Grants one master at a time, round-robin, and holds that grant for the whole transaction: address, every data beat up to WLAST, and the B response.
- Sits between the counter masters and the system interconnect.
- Exposes the current grant and busy state for the status register.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- DATA_WIDTH, 32, W data width.
- ADDR_WIDTH, 64, AW address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-low reset
- s_awid_i  in  NUM_MASTERS*4  per-master AWID, master k in slice [k*4 +: 4]; all s_* vectors are packed the same way
- s_awlen_i  in  NUM_MASTERS*4  per-master burst length
- s_awsize_i  in  NUM_MASTERS*3  per-master burst size
- s_awburst_i  in  NUM_MASTERS*2  per-master burst type
- s_awaddr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address
- s_awvalid_i  in  NUM_MASTERS  AW valid; also the arbitration request
- s_awready_o  out  NUM_MASTERS  AW ready
- s_wdata_i  in  NUM_MASTERS*DATA_WIDTH  W data
- s_wstrb_i  in  NUM_MASTERS*STRB_WIDTH  W strobes
- s_wlast_i  in  NUM_MASTERS  W last
- s_wvalid_i  in  NUM_MASTERS  W valid
- s_wready_o  out  NUM_MASTERS  W ready
- s_bid_o  out  NUM_MASTERS*4  B id
- s_bresp_o  out  NUM_MASTERS*2  B response
- s_bvalid_o  out  NUM_MASTERS  B valid
- s_bready_i  in  NUM_MASTERS  B ready
- m_awid_o, m_awlen_o, m_awsize_o, m_awburst_o, m_awaddr_o, m_awvalid_o  out  4/4/3/2/ADDR_WIDTH/1  downstream AW
- m_awready_i  in  1  downstream AW ready
- m_wdata_o, m_wstrb_o, m_wlast_o, m_wvalid_o  out  DATA_WIDTH/STRB_WIDTH/1/1  downstream W
- m_wready_i  in  1  downstream W ready
- m_bid_i, m_bresp_i, m_bvalid_i  in  4/2/1  downstream B
- m_bready_o  out  1  downstream B ready
- grant_o  out  NUM_MASTERS  one-hot current grant, 0 when idle
- busy_o  out  1  high in any state other than IDLE
- state_o  out  2  encoded FSM state

Behaviour:
- Reset (areset low, asynchronous):
  - FSM goes to IDLE; grant_o=0; rr pointer=0 (master 0 has highest priority); busy_o=0.
  - All combinational outputs evaluate to 0: every valid and ready output, and all m_* payloads.
  - Reset mid-transaction abandons the transaction; no partial handshake completes after reset.
- FSM: IDLE(0) -> ADDR(1) -> DATA(2) -> RESP(3) -> IDLE.
- IDLE:
  - If any s_awvalid_i bit is set, register a one-hot grant. Selection starts at index rr_ptr and wraps modulo NUM_MASTERS; the first requesting master wins.
  - Next state is ADDR. Grant latency is 1 cycle.
- ADDR:
  - m_aw* = granted master's AW payload; m_awvalid_o = granted s_awvalid_i.
  - s_awready_o[g] = m_awready_i; all other masters see 0.
  - On m_awvalid_o & m_awready_i, go to DATA.
  - If the granted master drops awvalid, stay in ADDR (no re-arbitration).
- DATA:
  - W is routed from the granted master: m_w* = s_w*[g]; s_wready_o[g] = m_wready_i.
  - Transition to RESP only on a beat with m_wvalid_o & m_wready_i & m_wlast_o.
  - No beat counting: a master that never asserts wlast holds the arbiter indefinitely.
- RESP:
  - s_bvalid_o[g] = m_bvalid_i; s_bid_o/s_bresp_o[g] = m_bid_i/m_bresp_i; m_bready_o = s_bready_i[g].
  - On the B handshake: set rr_ptr = (g+1) mod NUM_MASTERS, clear the grant, go to IDLE.
- Non-granted masters always see awready=0, wready=0, bvalid=0; their B payload is 0. W asserted before the grant is held off.
- Outside DATA, m_wvalid_o=0. Outside ADDR, m_awvalid_o=0. Outside RESP, m_bready_o=0.
- One outstanding transaction only. Minimum turnaround from B handshake to the next AW valid is 2 cycles (IDLE, then ADDR).
- bresp is passed through unmodified, including SLVERR/DECERR. The arbiter takes no action on errors.
- All handshake paths are combinational through the registered grant. There is no payload buffering.

Test Plan:
- Single requester: master 2 raises awvalid with addr 0x0000_0000_1000_0000, len 0, data 0x5 with wlast -> grant_o=0b0100 next cycle; m_awaddr_o matches; m_wdata_o=0x5; B OKAY delivered only to master 2; back to IDLE with rr_ptr=3.
- Contention: all 4 masters request after reset -> grant order 0,1,2,3,0; each grant is held until its B handshake; no overlap in grant_o.
- Burst: master 1 len=3, four beats 0x10..0x13, m_wready_i toggling every other cycle -> exactly 4 W handshakes forwarded; RESP entered only after the beat carrying wlast.
- Isolation: master 3 asserts wvalid while master 0 is granted -> s_wready_o[3]=0 throughout; master 3's data never appears on m_wdata_o.
- Error/backpressure: m_bresp_i=2'b10 with s_bready_i[g] low for 5 cycles -> s_bvalid_o[g] held, state_o=3 for 5 cycles; SLVERR passed through; then IDLE.
- Reset mid-burst: areset low during DATA beat 2 -> all valids and readies 0 and grant_o=0 immediately; after release, master 0 wins first.
